// File: rtl/eth_prbs_gen_chk_pkg.sv
// eth_prbs_gen_chk_pkg
//   Shared definitions for the PRBS generator/checker: mode encodings,
//   LFSR order/tap tables (maximum order 31) and checker state encodings.
//   Ports: none (package).
package eth_prbs_gen_chk_pkg;

   localparam int PRBS_MAX_ORDER = 31;

   typedef enum logic [1:0] {
      PRBS_MODE_7  = 2'd0,
      PRBS_MODE_15 = 2'd1,
      PRBS_MODE_23 = 2'd2,
      PRBS_MODE_31 = 2'd3
   } prbs_mode_t;

   typedef enum logic {
      CHK_HUNT   = 1'b0,
      CHK_LOCKED = 1'b1
   } chk_state_t;

   function automatic int prbs_order(input int mode);
      case (mode)
         0:       return 7;
         1:       return 15;
         2:       return 23;
         default: return 31;
      endcase
   endfunction

   function automatic int prbs_tap(input int mode);
      case (mode)
         0:       return 6;
         1:       return 14;
         2:       return 18;
         default: return 28;
      endcase
   endfunction

   // Keeps only the N live state bits of the selected polynomial.
   function automatic logic [PRBS_MAX_ORDER-1:0] prbs_mask(input logic [1:0] mode);
      case (mode)
         2'd0:    return 31'h0000_007F;
         2'd1:    return 31'h0000_7FFF;
         2'd2:    return 31'h007F_FFFF;
         default: return 31'h7FFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/eth_prbs_gen_chk_if.sv
// eth_prbs_gen_chk_if
//   TX/RX data path bundle of the PRBS generator/checker.
//   gen_data/gen_valid : generated word toward the line (driven by the block)
//   chk_data/chk_valid : received word under test (driven by the link side)
//   Modports: master = PRBS block, slave = link / loopback side.
interface eth_prbs_gen_chk_if #(
   parameter int DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0] gen_data;
   logic                  gen_valid;
   logic [DATA_WIDTH-1:0] chk_data;
   logic                  chk_valid;

   modport master (output gen_data, gen_valid, input chk_data, chk_valid);
   modport slave  (input gen_data, gen_valid, output chk_data, chk_valid);
endinterface

// File: rtl/eth_prbs_lfsr_step.sv
// eth_prbs_lfsr_step
//   Combinational DATA_WIDTH-bit advance of the selected PRBS LFSR.
//   Each step: b = s[N-1]^s[T-1]; s <= {s[N-2:0],b}; word bit i = i-th b.
//   mode       in  2                 polynomial select (PRBS7/15/23/31)
//   state      in  PRBS_MAX_ORDER    current state (bits >= N ignored)
//   word       out DATA_WIDTH        generated word, bit 0 first
//   state_next out PRBS_MAX_ORDER    state after DATA_WIDTH steps
module eth_prbs_lfsr_step
   import eth_prbs_gen_chk_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [1:0]                mode,
   input  logic [PRBS_MAX_ORDER-1:0] state,
   output logic [DATA_WIDTH-1:0]     word,
   output logic [PRBS_MAX_ORDER-1:0] state_next
);

   // One fully unrolled advance per polynomial, selected afterwards.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mode
         localparam int N = prbs_order(gi);
         localparam int T = prbs_tap(gi);
         localparam logic [PRBS_MAX_ORDER-1:0] MASK = prbs_mask(2'(gi));

         logic [DATA_WIDTH-1:0]     w;
         logic [PRBS_MAX_ORDER-1:0] sn;

         always_comb begin
            logic [PRBS_MAX_ORDER-1:0] s;
            logic                      b;
            w = '0;
            s = state & MASK;
            b = 1'b0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
               b    = s[N-1] ^ s[T-1];
               w[i] = b;
               s    = ((s << 1) | {{(PRBS_MAX_ORDER-1){1'b0}}, b}) & MASK;
            end
            sn = s;
         end
      end
   endgenerate

   always_comb begin
      word       = g_mode[3].w;
      state_next = g_mode[3].sn;
      case (mode)
         2'd0: begin word = g_mode[0].w; state_next = g_mode[0].sn; end
         2'd1: begin word = g_mode[1].w; state_next = g_mode[1].sn; end
         2'd2: begin word = g_mode[2].w; state_next = g_mode[2].sn; end
         default: ;
      endcase
   end

endmodule

// File: rtl/eth_prbs_gen_chk.sv
// eth_prbs_gen_chk
//   PRBS7/15/23/31 generator and self-synchronising checker for PHY BER test.
//   clk, rst        single clock, synchronous active-high reset
//   cfg_mode        polynomial select; a change reseeds generator, unlocks checker
//   cfg_gen_enable  generator advances one word per clk while high
//   cfg_chk_enable  checker runs while high, low forces HUNT
//   cnt_clear       synchronous clear of chk_err_count (wins over an increment)
//   err_inject      (ETH_PRBS_ERR_INJECT_EN only) rising edge flips bit 0 of next word
//   chk_locked      checker in LOCKED
//   chk_err_word    1-clk pulse, last word checked in LOCKED had bit errors
//   chk_err_count   saturating bit-error total
//   bus             gen_data/gen_valid out, chk_data/chk_valid in
//   Optional feature macro: ETH_PRBS_ERR_INJECT_EN.
module eth_prbs_gen_chk
   import eth_prbs_gen_chk_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16,
   parameter int LOCK_GOOD  = 8,
   parameter int LOCK_BAD   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           cfg_mode,
   input  logic                 cfg_gen_enable,
   input  logic                 cfg_chk_enable,
   input  logic                 cnt_clear,
`ifdef ETH_PRBS_ERR_INJECT_EN
   input  logic                 err_inject,
`endif
   output logic                 chk_locked,
   output logic                 chk_err_word,
   output logic [CNT_WIDTH-1:0] chk_err_count,
   eth_prbs_gen_chk_if.master   bus
);

   localparam int PCW = $clog2(DATA_WIDTH + 1);
   localparam int SW  = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;
   localparam int GW  = $clog2(LOCK_GOOD + 1);
   localparam int BW  = $clog2(LOCK_BAD + 1);

   logic [1:0]                mode_reg;
   logic                      mode_change;
   logic [PRBS_MAX_ORDER-1:0] gen_state_reg;
   logic [DATA_WIDTH-1:0]     gen_data_reg;
   logic                      gen_valid_reg;
   logic [DATA_WIDTH-1:0]     gen_word;
   logic [PRBS_MAX_ORDER-1:0] gen_state_next;
   logic [DATA_WIDTH-1:0]     inj_mask;

   chk_state_t                chk_state_reg, chk_state_next;
   logic [PRBS_MAX_ORDER-1:0] seed_reg, seed_next;
   logic [GW-1:0]             good_cnt_reg, good_cnt_next;
   logic [BW-1:0]             bad_cnt_reg, bad_cnt_next;
   logic                      err_word_reg, err_word_next;
   logic [CNT_WIDTH-1:0]      err_count_reg, err_count_next;

   logic [DATA_WIDTH-1:0]     pred_word;
   logic [PRBS_MAX_ORDER-1:0] pred_next;
   logic [PRBS_MAX_ORDER-1:0] rx_seed_raw, rx_seed;
   logic                      seed_live;
   logic [PCW-1:0]            err_bits;
   logic [SW-1:0]             err_sum;
   logic [CNT_WIDTH-1:0]      err_sum_sat;

   assign mode_change = (cfg_mode != mode_reg);

   // ---------------- generator ----------------
   eth_prbs_lfsr_step #(.DATA_WIDTH(DATA_WIDTH)) u_gen_step (
      .mode       (cfg_mode),
      .state      (gen_state_reg),
      .word       (gen_word),
      .state_next (gen_state_next)
   );

`ifdef ETH_PRBS_ERR_INJECT_EN
   logic inj_prev_reg;
   always_ff @(posedge clk) begin
      if (rst) inj_prev_reg <= 1'b0;
      else     inj_prev_reg <= err_inject;
   end
   // Edge-detected so a held-high request corrupts exactly one word.
   assign inj_mask = {{(DATA_WIDTH-1){1'b0}}, err_inject & ~inj_prev_reg};
`else
   assign inj_mask = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg      <= cfg_mode;
         gen_state_reg <= '1;
         gen_data_reg  <= '0;
         gen_valid_reg <= 1'b0;
      end else begin
         mode_reg      <= cfg_mode;
         gen_valid_reg <= 1'b0;
         // A mode change spends one clk reseeding so no mixed-mode word escapes.
         if (mode_change) begin
            gen_state_reg <= '1;
         end else if (cfg_gen_enable) begin
            gen_state_reg <= gen_state_next;
            gen_data_reg  <= gen_word ^ inj_mask;
            gen_valid_reg <= 1'b1;
         end
      end
   end

   assign bus.gen_data  = gen_data_reg;
   assign bus.gen_valid = gen_valid_reg;

   // ---------------- checker ----------------
   // Prediction comes from the last received word in HUNT and from the
   // free-running state in LOCKED; both live in seed_reg.
   eth_prbs_lfsr_step #(.DATA_WIDTH(DATA_WIDTH)) u_chk_step (
      .mode       (cfg_mode),
      .state      (seed_reg),
      .word       (pred_word),
      .state_next (pred_next)
   );

   // The last N bits of a word are the LFSR state after that word (MSB = s[0]).
   genvar gi;
   generate
      for (gi = 0; gi < PRBS_MAX_ORDER; gi++) begin : g_seed
         assign rx_seed_raw[gi] = bus.chk_data[DATA_WIDTH-1-gi];
      end
   endgenerate
   assign rx_seed   = rx_seed_raw & prbs_mask(cfg_mode);
   assign seed_live = |(seed_reg & prbs_mask(cfg_mode));

   always_comb begin
      err_bits = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         err_bits = err_bits + PCW'(bus.chk_data[i] ^ pred_word[i]);
      end
   end

   assign err_sum     = SW'(err_count_reg) + SW'(err_bits);
   assign err_sum_sat = (err_sum > SW'({CNT_WIDTH{1'b1}})) ? {CNT_WIDTH{1'b1}}
                                                           : err_sum[CNT_WIDTH-1:0];

   always_comb begin
      chk_state_next = chk_state_reg;
      seed_next      = seed_reg;
      good_cnt_next  = good_cnt_reg;
      bad_cnt_next   = bad_cnt_reg;
      err_word_next  = 1'b0;
      err_count_next = err_count_reg;

      if (mode_change || !cfg_chk_enable) begin
         // Zero seed guarantees the first word after restart only reseeds.
         chk_state_next = CHK_HUNT;
         seed_next      = '0;
         good_cnt_next  = '0;
         bad_cnt_next   = '0;
      end else if (bus.chk_valid) begin
         if (chk_state_reg == CHK_HUNT) begin
            seed_next = rx_seed;
            // An all-zero seed predicts all-zero data; never count that as good.
            if (seed_live && (pred_word == bus.chk_data)) begin
               if (good_cnt_reg == GW'(LOCK_GOOD - 1)) begin
                  chk_state_next = CHK_LOCKED;
                  good_cnt_next  = '0;
                  bad_cnt_next   = '0;
               end else begin
                  good_cnt_next = good_cnt_reg + 1'b1;
               end
            end else begin
               good_cnt_next = '0;
            end
         end else begin
            seed_next = pred_next;
            if (err_bits != '0) begin
               err_word_next  = 1'b1;
               err_count_next = err_sum_sat;
               if (bad_cnt_reg == BW'(LOCK_BAD - 1)) begin
                  chk_state_next = CHK_HUNT;
                  bad_cnt_next   = '0;
                  good_cnt_next  = '0;
               end else begin
                  bad_cnt_next = bad_cnt_reg + 1'b1;
               end
            end else begin
               bad_cnt_next = '0;
            end
         end
      end

      if (cnt_clear) err_count_next = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_state_reg <= CHK_HUNT;
         seed_reg      <= '0;
         good_cnt_reg  <= '0;
         bad_cnt_reg   <= '0;
         err_word_reg  <= 1'b0;
         err_count_reg <= '0;
      end else begin
         chk_state_reg <= chk_state_next;
         seed_reg      <= seed_next;
         good_cnt_reg  <= good_cnt_next;
         bad_cnt_reg   <= bad_cnt_next;
         err_word_reg  <= err_word_next;
         err_count_reg <= err_count_next;
      end
   end

   assign chk_locked    = (chk_state_reg == CHK_LOCKED);
   assign chk_err_word  = err_word_reg;
   assign chk_err_count = err_count_reg;

endmodule

// File: tb/tb_eth_prbs_gen_chk.sv
// tb_eth_prbs_gen_chk
//   Loopback bench: two instances (16-bit and 4-bit error counters) share the
//   same stimulus; the RX path is the TX word XOR an error mask, or forced zero.
//   Expected first words after reseed (low 32 bits, from all-ones state):
//     PRBS7 0x4F143040, PRBS15 0x30004000, PRBS23 0x007C0000, PRBS31 0x70000000.
module tb_eth_prbs_gen_chk;
   localparam int DW = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, gen_en, chk_en, cnt_clear, err_inject, zero_rx;
   logic [1:0]    cfg_mode;
   logic [DW-1:0] flip_mask;
   logic          locked_a, err_word_a, locked_b, err_word_b;
   logic [15:0]   count_a;
   logic [3:0]    count_b;
   int            compared = 0;
   int            mismatched = 0;

   eth_prbs_gen_chk_if #(.DATA_WIDTH(DW)) bus_a ();
   eth_prbs_gen_chk_if #(.DATA_WIDTH(DW)) bus_b ();

   assign bus_a.chk_data  = zero_rx ? '0 : (bus_a.gen_data ^ flip_mask);
   assign bus_a.chk_valid = bus_a.gen_valid;
   assign bus_b.chk_data  = zero_rx ? '0 : (bus_b.gen_data ^ flip_mask);
   assign bus_b.chk_valid = bus_b.gen_valid;

   eth_prbs_gen_chk #(.DATA_WIDTH(DW), .CNT_WIDTH(16), .LOCK_GOOD(8), .LOCK_BAD(4)) dut_a (
      .clk            (clk),
      .rst            (rst),
      .cfg_mode       (cfg_mode),
      .cfg_gen_enable (gen_en),
      .cfg_chk_enable (chk_en),
      .cnt_clear      (cnt_clear),
`ifdef ETH_PRBS_ERR_INJECT_EN
      .err_inject     (err_inject),
`endif
      .chk_locked     (locked_a),
      .chk_err_word   (err_word_a),
      .chk_err_count  (count_a),
      .bus            (bus_a)
   );

   eth_prbs_gen_chk #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .LOCK_GOOD(8), .LOCK_BAD(4)) dut_b (
      .clk            (clk),
      .rst            (rst),
      .cfg_mode       (cfg_mode),
      .cfg_gen_enable (gen_en),
      .cfg_chk_enable (chk_en),
      .cnt_clear      (cnt_clear),
`ifdef ETH_PRBS_ERR_INJECT_EN
      .err_inject     (err_inject),
`endif
      .chk_locked     (locked_b),
      .chk_err_word   (err_word_b),
      .chk_err_count  (count_b),
      .bus            (bus_b)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts valid words presented until lock (bounded) and captures the first one.
   task automatic wait_lock(input string tag, output int words, output logic [31:0] first);
      bit got_first;
      words     = 0;
      first     = '0;
      got_first = 0;
      for (int c = 0; c < 40 && !locked_a; c++) begin
         if (bus_a.chk_valid) begin
            if (!got_first) begin
               first     = bus_a.gen_data[31:0];
               got_first = 1;
            end
            words++;
         end
         tick();
      end
      check_eq({tag, " locked"}, 64'(locked_a), 64'd1);
      check_eq({tag, " locked_b"}, 64'(locked_b), 64'd1);
   endtask

   task automatic run_clean(input string tag, input int n);
      bit seen;
      seen = 0;
      for (int c = 0; c < n; c++) begin
         tick();
         if (err_word_a || !locked_a) seen = 1;
      end
      check_eq({tag, " clean run err/unlock"}, 64'(seen), 64'd0);
      check_eq({tag, " clean run count"}, 64'(count_a), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          words;
      logic [31:0] first;
      logic [31:0] first_tbl [3];
      int          pulses;
      first_tbl[0] = 32'h4F14_3040;
      first_tbl[1] = 32'h3000_4000;
      first_tbl[2] = 32'h007C_0000;

      rst = 1; cfg_mode = 2'd3; gen_en = 0; chk_en = 1; cnt_clear = 0;
      err_inject = 0; zero_rx = 0; flip_mask = '0;
      repeat (3) tick();
      check_eq("reset gen_data", bus_a.gen_data, 64'd0);
      check_eq("reset gen_valid", 64'(bus_a.gen_valid), 64'd0);
      check_eq("reset locked", 64'(locked_a), 64'd0);
      check_eq("reset err_word", 64'(err_word_a), 64'd0);
      check_eq("reset count", 64'(count_a), 64'd0);
      rst = 0;
      tick();
      check_eq("gen_valid while disabled", 64'(bus_a.gen_valid), 64'd0);

      // PRBS31 bring-up
      gen_en = 1;
      tick();
      check_eq("gen_valid 1 clk after enable", 64'(bus_a.gen_valid), 64'd1);
      check_eq("prbs31 first word", 64'(bus_a.gen_data[31:0]), 64'h7000_0000);
      wait_lock("prbs31", words, first);
      check_eq("prbs31 words to lock", 64'(words), 64'd9);
      run_clean("prbs31", 1000);

      // Disable holds state: LOCKED checker must see no error after resume
      gen_en = 0;
      repeat (3) tick();
      check_eq("gen_valid disabled", 64'(bus_a.gen_valid), 64'd0);
      gen_en = 1;
      run_clean("resume", 20);

      // Mode switches 3->0->1->2
      for (int m = 0; m < 3; m++) begin
         cfg_mode = 2'(m);
         tick();
         check_eq($sformatf("mode%0d switch drops lock", m), 64'(locked_a), 64'd0);
         check_eq($sformatf("mode%0d switch err_word", m), 64'(err_word_a), 64'd0);
         wait_lock($sformatf("mode%0d", m), words, first);
         check_eq($sformatf("mode%0d words to lock", m), 64'(words), 64'd9);
         check_eq($sformatf("mode%0d first word", m), 64'(first), 64'(first_tbl[m]));
         run_clean($sformatf("mode%0d", m), 1000);
      end

      // Three flipped bits in one word
      flip_mask = 64'h8000_0000_0000_0021;
      tick();
      flip_mask = '0;
      check_eq("3-bit err_word", 64'(err_word_a), 64'd1);
      check_eq("3-bit count", 64'(count_a), 64'd3);
      check_eq("3-bit count_b", 64'(count_b), 64'd3);
      tick();
      check_eq("3-bit err_word pulse end", 64'(err_word_a), 64'd0);
      check_eq("3-bit lock kept", 64'(locked_a), 64'd1);

      // Saturation with a 4-bit counter
      cnt_clear = 1;
      tick();
      cnt_clear = 0;
      check_eq("clear count", 64'(count_a), 64'd0);
      check_eq("clear count_b", 64'(count_b), 64'd0);
      flip_mask = 64'hFF;
      tick();
      check_eq("sat word1 count_b", 64'(count_b), 64'd8);
      tick();
      check_eq("sat word2 count_b", 64'(count_b), 64'd15);
      check_eq("sat word2 count", 64'(count_a), 64'd16);
      tick();
      check_eq("sat word3 count_b", 64'(count_b), 64'd15);
      check_eq("sat word3 count", 64'(count_a), 64'd24);
      flip_mask = '0;
      tick();
      check_eq("sat hold count_b", 64'(count_b), 64'd15);
      check_eq("3 bad words keep lock", 64'(locked_a), 64'd1);
      cnt_clear = 1;
      flip_mask = 64'hFF;
      tick();
      cnt_clear = 0;
      flip_mask = '0;
      check_eq("clear beats increment", 64'(count_a), 64'd0);
      check_eq("clear beats increment err_word", 64'(err_word_a), 64'd1);
      check_eq("clear beats increment count_b", 64'(count_b), 64'd0);

      // All-zero input: drop lock after 4 bad words, never relock on zeros
      tick();
      zero_rx = 1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_eq($sformatf("zero word%0d err_word", k), 64'(err_word_a), 64'd1);
         check_eq($sformatf("zero word%0d locked", k), 64'(locked_a), (k < 4) ? 64'd1 : 64'd0);
      end
      pulses = 0;
      repeat (20) begin
         tick();
         if (locked_a || err_word_a) pulses++;
      end
      check_eq("hunt on zeros stays unlocked", 64'(pulses), 64'd0);
      zero_rx = 0;
      wait_lock("relock after zeros", words, first);
      check_eq("relock words", 64'(words), 64'd9);

`ifdef ETH_PRBS_ERR_INJECT_EN
      cnt_clear = 1;
      tick();
      cnt_clear = 0;
      err_inject = 1;
      tick();
      err_inject = 0;
      tick();
      check_eq("inject err_word", 64'(err_word_a), 64'd1);
      check_eq("inject count", 64'(count_a), 64'd1);
      tick();
      check_eq("inject pulse end", 64'(err_word_a), 64'd0);
      pulses = 0;
      err_inject = 1;
      repeat (3) begin
         tick();
         if (err_word_a) pulses++;
      end
      err_inject = 0;
      repeat (2) begin
         tick();
         if (err_word_a) pulses++;
      end
      check_eq("held inject single pulse", 64'(pulses), 64'd1);
      check_eq("held inject count", 64'(count_a), 64'd2);
`endif

      // Reset mid-run
      rst = 1;
      tick();
      check_eq("midrun reset gen_data", bus_a.gen_data, 64'd0);
      check_eq("midrun reset gen_valid", 64'(bus_a.gen_valid), 64'd0);
      check_eq("midrun reset locked", 64'(locked_a), 64'd0);
      check_eq("midrun reset err_word", 64'(err_word_a), 64'd0);
      check_eq("midrun reset count", 64'(count_a), 64'd0);
      check_eq("midrun reset count_b", 64'(count_b), 64'd0);
      rst = 0;
      tick();
      check_eq("post reset first word", 64'(bus_a.gen_data[31:0]), 64'h007C_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
